// File: rtl/lsu_aligned_ctrl.sv
// Load/store unit: one EXU transaction at a time over split load/store bus channels,
// with byte-lane alignment, misalignment trapping, bus timeout and registered responses.
module lsu_aligned_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                resp_misalign,
    output logic [ADDR_W-1:0]   lsu_araddr_o,
    output logic                lsu_arvalid_o,
    input  logic                lsu_arready,
    input  logic [DATA_W-1:0]   lsu_rdata,
    input  logic                lsu_rvalid,
    input  logic                lsu_rerr,
    output logic [ADDR_W-1:0]   lsu_awaddr_o,
    output logic                lsu_awvalid_o,
    input  logic                lsu_awready,
    output logic [DATA_W-1:0]   lsu_wdata_o,
    output logic [DATA_W/8-1:0] lsu_wstrb_o,
    output logic                lsu_wvalid_o,
    input  logic                lsu_wready,
    input  logic                lsu_bvalid,
    input  logic                lsu_berr
);

    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned OW = $clog2(NB);
    localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLIM = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [6:0] DW7 = 7'(DATA_W);

    typedef enum logic [2:0] {StIdle, StRdA, StRdD, StWr, StWrB, StResp} state_e;

    state_e            r_state;
    logic [ADDR_W-1:0] r_baddr;
    logic [OW-1:0]     r_off;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [DATA_W-1:0] r_wdata;
    logic [NB-1:0]     r_wstrb;
    logic              r_arvalid;
    logic              r_awvalid;
    logic              r_wvalid;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic              r_mis;
    logic [TW-1:0]     r_cnt;

    logic [OW-1:0]     w_off;
    logic [2:0]        w_amask;
    logic              w_mis;
    logic [NB-1:0]     w_lane_mask;
    logic [DATA_W-1:0] w_rsh;
    logic [6:0]        w_nbits;
    logic [6:0]        w_ext_amt;
    logic [DATA_W-1:0] w_lsh;
    logic [DATA_W-1:0] w_zext;
    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_ldata;
    logic              w_tmo;
    logic              w_aw_done;
    logic              w_w_done;

    assign w_off = req_addr[OW-1:0];

    always_comb begin
        w_amask     = 3'b000;
        w_lane_mask = NB'(1);
        unique case (req_size)
            2'd0: begin w_amask = 3'b000; w_lane_mask = NB'(8'h01); end
            2'd1: begin w_amask = 3'b001; w_lane_mask = NB'(8'h03); end
            2'd2: begin w_amask = 3'b011; w_lane_mask = NB'(8'h0F); end
            2'd3: begin w_amask = 3'b111; w_lane_mask = NB'(8'hFF); end
        endcase
    end

    assign w_mis = (|(req_addr[2:0] & w_amask)) | ((req_size == 2'd3) && (DATA_W == 32));

    // Extract the lane, then sign/zero-extend by shifting it to the top and back down.
    assign w_rsh     = lsu_rdata >> {r_off, 3'b000};
    assign w_nbits   = 7'd8 << r_size;
    assign w_ext_amt = (w_nbits >= DW7) ? 7'd0 : DW7 - w_nbits;
    assign w_lsh     = w_rsh << w_ext_amt;
    assign w_zext    = w_lsh >> w_ext_amt;
    assign w_sext    = $signed(w_lsh) >>> w_ext_amt;
    assign w_ldata   = r_unsigned ? w_zext : w_sext;

    assign w_tmo     = (TIMEOUT != 0) && (r_cnt == TLIM);
    assign w_aw_done = ~r_awvalid | lsu_awready;
    assign w_w_done  = ~r_wvalid | lsu_wready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_baddr      <= '0;
            r_off        <= '0;
            r_size       <= '0;
            r_unsigned   <= 1'b0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_arvalid    <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_mis        <= 1'b0;
            r_cnt        <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (req_valid) begin
                        r_baddr    <= {req_addr[ADDR_W-1:OW], {OW{1'b0}}};
                        r_off      <= w_off;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_wdata    <= req_wdata << {w_off, 3'b000};
                        r_wstrb    <= w_lane_mask << w_off;
                        r_rdata    <= '0;
                        r_err      <= 1'b0;
                        r_mis      <= w_mis;
                        r_cnt      <= '0;
                        if (w_mis) begin
                            r_resp_valid <= 1'b1;
                            r_state      <= StResp;
                        end else if (req_wen) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= StWr;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= StRdA;
                        end
                    end
                end
                StRdA, StRdD: begin
                    r_cnt <= r_cnt + TW'(1);
                    if (lsu_rvalid) begin
                        // Early read data (before arready) also completes the load.
                        r_rdata      <= lsu_rerr ? '0 : w_ldata;
                        r_err        <= lsu_rerr;
                        r_arvalid    <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= StResp;
                    end else if (r_state == StRdA && lsu_arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= StRdD;
                    end else if (w_tmo) begin
                        r_arvalid    <= 1'b0;
                        r_err        <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_state      <= StResp;
                    end
                end
                StWr: begin
                    r_cnt     <= r_cnt + TW'(1);
                    r_awvalid <= r_awvalid & ~lsu_awready;
                    r_wvalid  <= r_wvalid & ~lsu_wready;
                    if (w_aw_done && w_w_done) begin
                        r_state <= StWrB;
                    end else if (w_tmo) begin
                        r_awvalid    <= 1'b0;
                        r_wvalid     <= 1'b0;
                        r_err        <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_state      <= StResp;
                    end
                end
                StWrB: begin
                    r_cnt <= r_cnt + TW'(1);
                    if (lsu_bvalid) begin
                        r_err        <= lsu_berr;
                        r_resp_valid <= 1'b1;
                        r_state      <= StResp;
                    end else if (w_tmo) begin
                        r_err        <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_state      <= StResp;
                    end
                end
                StResp: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign req_ready     = (r_state == StIdle);
    assign resp_valid    = r_resp_valid;
    assign resp_rdata    = r_rdata;
    assign resp_err      = r_err;
    assign resp_misalign = r_mis;
    assign lsu_araddr_o  = r_baddr;
    assign lsu_arvalid_o = r_arvalid;
    assign lsu_awaddr_o  = r_baddr;
    assign lsu_awvalid_o = r_awvalid;
    assign lsu_wdata_o   = r_wdata;
    assign lsu_wstrb_o   = r_wstrb;
    assign lsu_wvalid_o  = r_wvalid;

endmodule

// File: doc/lsu_aligned_ctrl.md
Name: lsu_aligned_ctrl

Overview:
- Load/store unit between EXU and the data bus; one transaction in flight at a time.
- EXU side is a valid/ready request and response pair. The bus side uses separate load and store channels with handshakes, write response and error.
- Over the previous LSU it adds: byte-lane alignment from the low address bits, 64-bit data support, misalignment trapping, a per-transaction bus timeout, and registered responses with backpressure.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, bus/data width; legal values 32 or 64
TIMEOUT, 255, max cycles waiting in any bus state before abort; 0 disables the timeout

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  EXU request valid
req_ready  out  1  LSU can accept a request
req_wen  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double (double legal only when DATA_W=64)
req_unsigned  in  1  zero-extend load result
req_wdata  in  DATA_W  store data, LSB-justified
resp_valid  out  1  response valid
resp_ready  in  1  EXU accepts the response
resp_rdata  out  DATA_W  extended load data; 0 for stores and for errors
resp_err  out  1  bus error or timeout
resp_misalign  out  1  misaligned or illegal size
lsu_araddr_o  out  ADDR_W  load address, aligned down to DATA_W/8
lsu_arvalid_o  out  1  load address valid
lsu_arready  in  1  load address accepted
lsu_rdata  in  DATA_W  load data
lsu_rvalid  in  1  load data valid
lsu_rerr  in  1  load bus error, qualified by lsu_rvalid
lsu_awaddr_o  out  ADDR_W  store address, aligned down
lsu_awvalid_o  out  1  store address valid
lsu_awready  in  1  store address accepted
lsu_wdata_o  out  DATA_W  lane-shifted store data
lsu_wstrb_o  out  DATA_W/8  byte strobes
lsu_wvalid_o  out  1  store data valid
lsu_wready  in  1  store data accepted
lsu_bvalid  in  1  store response valid
lsu_berr  in  1  store bus error, qualified by lsu_bvalid

Behaviour:
Reset:
- rst_n low puts the FSM in IDLE asynchronously.
- All *valid outputs, resp_err, resp_misalign, resp_rdata and the timeout counter go to 0.
- Any transaction in progress is dropped without a response.

FSM states: IDLE, RD_A, RD_D, WR, WR_B, RESP.

IDLE:
- req_ready=1 in IDLE only.
- On req_valid&req_ready, latch addr, size, unsigned, wen and wdata.
- Compute off = addr[log2(DATA_W/8)-1:0].
- Misaligned when (addr mod 2^size) != 0, or when size=3 with DATA_W=32. In that case go to RESP with resp_misalign=1 and issue no bus traffic.
- Otherwise go to RD_A for a load or WR for a store.

RD_A:
- lsu_arvalid_o=1 (registered, first asserted the cycle after acceptance). Hold arvalid and araddr stable until lsu_arready.
- If lsu_rvalid arrives in the same cycle as or before lsu_arready, capture it and go to RESP.
- Otherwise go to RD_D.

RD_D:
- Wait for lsu_rvalid.
- Register the result: data = lsu_rdata >> (8*off), truncated to 8<<size bits, then sign- or zero-extended to DATA_W.
- resp_err = lsu_rerr. Go to RESP.

WR:
- Assert lsu_awvalid_o and lsu_wvalid_o together. Each drops independently once its own ready is sampled high.
- lsu_wdata_o = wdata << (8*off).
- lsu_wstrb_o = ((1 << (1<<size)) - 1) << off.
- Once both channels have handshaken, go to WR_B.

WR_B:
- Wait for lsu_bvalid. resp_err = lsu_berr. Go to RESP.

Timeout:
- The counter is cleared on entry to RD_A/WR and increments every cycle in RD_A, RD_D, WR and WR_B.
- When it reaches TIMEOUT (TIMEOUT != 0): deassert all bus valids, set resp_err=1, go to RESP.
- Bus responses arriving later (rvalid or bvalid while in IDLE or RESP) are ignored.

RESP:
- resp_valid=1, with rdata/err/misalign held stable until resp_ready.
- On resp_ready, go to IDLE. The next request can be accepted the following cycle; there is no IDLE/RESP overlap.

Latency, zero-wait bus, resp_ready tied high:
- Load: accepted at cycle 0, arvalid at cycle 1, rvalid at cycle 2, resp_valid at cycle 3.
- Store: resp_valid is 1 cycle after bvalid.
- Misaligned request: resp_valid at cycle 1.

Test Plan:
- LB, addr 0x1003, unsigned=0, DATA_W=32, rdata 0x80FF1234 → araddr 0x1000, resp_rdata 0xFFFFFF80, resp_err=0. Same with LBU → 0x00000080.
- SH, addr 0x2002, wdata 0x0000BEEF → awaddr 0x2000, wdata 0xBEEF0000, wstrb 4'b1100. bvalid with berr=0 → resp_valid with err=0.
- LW at addr 0x1001 → resp_misalign=1 at cycle 1; arvalid never asserted. SD (size=3) at DATA_W=32 → misalign.
- DATA_W=64, LD at addr 0x8 with rdata 0x8000_0000_0000_0001 → rdata unchanged. LWU at 0xC with rdata 0xDEADBEEF_00000000 → 0x00000000DEADBEEF.
- TIMEOUT=4, load with lsu_rvalid held low → resp_err=1 exactly 4 cycles after arvalid first asserts. A late rvalid afterwards causes no second response.
- resp_ready held low for 5 cycles → resp_valid and resp_rdata stable, req_ready=0. Assert rst_n=0 while in RD_D → arvalid and resp_valid go to 0 immediately, FSM in IDLE.
